mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: LAT, default 2, memory wait states, legal range 1..7; DEPTH, default 256, data-memory words.
REQ-002 The clock port SHALL be: clk  in  1  rising-edge clock for all state.
REQ-003 The reset port SHALL be: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: mem_read  in  1  load request from the EX/MEM register.
REQ-005 Port: mem_write  in  1  store request from the EX/MEM register.
REQ-006 Port: in_ctl  in  3  writeback control bits, passed through unchanged.
REQ-007 Port: in_alu_out  in  32  byte address for loads/stores, or the ALU result otherwise.
REQ-008 Port: in_rd2  in  32  store data.
REQ-009 Port: in_wn  in  5  destination register number.
REQ-010 Port: in_pc  in  32  instruction PC.
REQ-011 Port: stall  out  1  combinational; while high, upstream SHALL hold all inputs stable.
REQ-012 Ports: out_ctl (3), out_rd (32), out_alu_out (32), out_wn (5), out_pc (32), out_err (1): all out, forming the registered MEM/WB bundle.

Function
REQ-013 A request SHALL be exactly one of mem_read/mem_write high with in_alu_out[1:0]==0; the word index SHALL be in_alu_out[9:2] modulo DEPTH.
REQ-014 FSM states SHALL be IDLE and BUSY, with counter cnt of 3 bits.
REQ-015 In IDLE, a request SHALL:
- assert stall combinationally in the same cycle;
- on the next edge, move to BUSY with cnt<=LAT-1 and out_ctl<=0 (bubble).
REQ-016 In BUSY with cnt!=0:
- stall SHALL be 1;
- each edge SHALL decrement cnt and load out_ctl<=0;
- the other outputs SHALL hold.
REQ-017 In BUSY with cnt==0:
- stall SHALL be 0;
- the edge SHALL commit a store, or capture out_rd<=mem[index] for a load;
- the edge SHALL register in_ctl, in_alu_out, in_wn and in_pc to the outputs, then return to IDLE.
REQ-018 A memory op SHALL therefore occupy LAT+1 cycles, with stall high for exactly LAT cycles and exactly one bubble per wait cycle.
REQ-019 Non-memory ops (both requests low) in IDLE SHALL pass in one cycle with stall=0 and out_rd<=0.
REQ-020 Both requests high, or a misaligned address, SHALL cause:
- no memory access and stall=0;
- out_ctl<=0 and out_err<=1 for one cycle.
Otherwise out_err<=0.
REQ-021 A store SHALL write the array exactly once, at the completing edge; a load issued immediately after a store to the same word SHALL return the new data.
REQ-022 Changes on request inputs while in BUSY SHALL be ignored; the captured request SHALL complete.

Reset
REQ-023 rst_n low SHALL immediately force:
- state IDLE, cnt 0;
- stall 0;
- all outputs 0.
REQ-024 Reset asserted mid-operation SHALL abort with no store committed; array contents SHALL NOT be reset.
REQ-025 After rst_n rises, the first edge SHALL sample inputs normally.

Structure
REQ-026 Package mem_pkg SHALL hold the state enum, the LAT and DEPTH defaults, and the ctl bit-field width.
REQ-027 The storage SHALL be sub-module dmem: DEPTH x 32, synchronous write, synchronous read, one port.
REQ-028 The FSM, counter and MEM/WB register SHALL reside in mem_stage; total RTL 120-400 lines.

Verification
REQ-029 With LAT=2, store 0xDEADBEEF at addr 0x10 -> stall high 2 cycles, two bubbles (out_ctl=0), mem[4]=0xDEADBEEF at the 3rd edge.
REQ-030 Load addr 0x10 right after REQ-029 -> out_rd=0xDEADBEEF on the 3rd edge with out_wn and out_ctl equal to the inputs.
REQ-031 ALU op (no request) with in_alu_out=0x1234, in_wn=7 -> stall 0, out_alu_out=0x1234 and out_wn=7 after 1 edge.
REQ-032 Load at addr 0x13 -> out_err=1 for 1 cycle, out_ctl=0, stall 0, memory unchanged.
REQ-033 Store 0xA5A5A5A5 to addr 0x20, with rst_n pulsed low in the first stall cycle -> outputs 0, state IDLE, mem[8] keeps its prior value.
REQ-034 With LAT=1, back-to-back loads -> stall high for exactly 1 cycle per load, one bubble each.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM pipeline stage and its data memory.
package mem_pkg;

    // Default number of memory wait states and data-memory depth in words
    localparam int LAT_DEFAULT   = 2;
    localparam int DEPTH_DEFAULT = 256;

    // Field widths of the EX/MEM and MEM/WB bundles
    localparam int CTL_W = 3;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 3;

    // IDLE accepts a new instruction; BUSY counts down the memory wait states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A word access needs the two low address bits clear
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Single-port data memory: synchronous write, synchronous registered read.
module dmem
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // One access per enabled edge: a write updates the array, otherwise the word is read out
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data memory, stalls upstream during the
// wait states and registers the MEM/WB bundle.
module mem_stage
    import mem_pkg::*;
#(
    parameter int LAT   = LAT_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [CTL_W-1:0] in_ctl,
    input  logic [XLEN-1:0]  in_alu_out,
    input  logic [XLEN-1:0]  in_rd2,
    input  logic [REG_W-1:0] in_wn,
    input  logic [XLEN-1:0]  in_pc,
    output logic             stall,
    output logic [CTL_W-1:0] out_ctl,
    output logic [XLEN-1:0]  out_rd,
    output logic [XLEN-1:0]  out_alu_out,
    output logic [REG_W-1:0] out_wn,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               req_load, req_load_n;
    logic [CTL_W-1:0]   out_ctl_n;
    logic [XLEN-1:0]    out_rd_n;
    logic [XLEN-1:0]    out_alu_out_n;
    logic [REG_W-1:0]   out_wn_n;
    logic [XLEN-1:0]    out_pc_n;
    logic               out_err_n;
    logic               stall_c;

    logic               aligned;
    logic               valid_req;
    logic               bad_req;
    logic [AW-1:0]      word_idx;
    logic               mem_en;
    logic               mem_we;
    logic [XLEN-1:0]    mem_rdata;
    logic               unused_addr_bits;

    // Request decode: exactly one of read/write with a word-aligned address
    assign aligned   = is_aligned(in_alu_out);
    assign valid_req = (mem_read ^ mem_write) & aligned;
    assign bad_req   = (mem_read & mem_write) | ((mem_read | mem_write) & ~aligned);
    assign word_idx  = AW'({24'd0, in_alu_out[9:2]} % DEPTH);

    assign unused_addr_bits = ^in_alu_out[XLEN-1:10];

    // Stall is suppressed while reset is held so upstream never sees a stale request
    assign stall = stall_c & rst_n;

    dmem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (in_rd2),
        .rdata (mem_rdata)
    );

    // Next-state, memory control and MEM/WB bundle; the memory is read on every
    // edge of a request so the data is ready whatever the wait-state count
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        req_load_n    = req_load;
        out_ctl_n     = out_ctl;
        out_rd_n      = out_rd;
        out_alu_out_n = out_alu_out;
        out_wn_n      = out_wn;
        out_pc_n      = out_pc;
        out_err_n     = 1'b0;
        stall_c       = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;

        case (state)
            IDLE: begin
                if (valid_req) begin
                    stall_c    = 1'b1;
                    mem_en     = 1'b1;
                    state_n    = BUSY;
                    cnt_n      = CNT_W'(LAT - 1);
                    req_load_n = mem_read;
                    out_ctl_n  = '0;
                end else if (bad_req) begin
                    out_ctl_n     = '0;
                    out_err_n     = 1'b1;
                    out_rd_n      = '0;
                    out_alu_out_n = in_alu_out;
                    out_wn_n      = in_wn;
                    out_pc_n      = in_pc;
                end else begin
                    out_ctl_n     = in_ctl;
                    out_rd_n      = '0;
                    out_alu_out_n = in_alu_out;
                    out_wn_n      = in_wn;
                    out_pc_n      = in_pc;
                end
            end

            BUSY: begin
                mem_en = 1'b1;
                if (cnt != '0) begin
                    stall_c   = 1'b1;
                    cnt_n     = cnt - 1'b1;
                    out_ctl_n = '0;
                end else begin
                    mem_we        = ~req_load;
                    out_rd_n      = req_load ? mem_rdata : '0;
                    out_ctl_n     = in_ctl;
                    out_alu_out_n = in_alu_out;
                    out_wn_n      = in_wn;
                    out_pc_n      = in_pc;
                    state_n       = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, wait counter, captured request type and MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_load    <= 1'b0;
            out_ctl     <= '0;
            out_rd      <= '0;
            out_alu_out <= '0;
            out_wn      <= '0;
            out_pc      <= '0;
            out_err     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            req_load    <= req_load_n;
            out_ctl     <= out_ctl_n;
            out_rd      <= out_rd_n;
            out_alu_out <= out_alu_out_n;
            out_wn      <= out_wn_n;
            out_pc      <= out_pc_n;
            out_err     <= out_err_n;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: one instance with LAT=2 and one with LAT=1,
// driven from vector tables and checked through an expected-result queue.
module tb_mem_stage;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  ctl;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wn;
        logic [31:0] pc;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic [2:0]  ctl;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wn;
        logic [31:0] pc;
        logic        err;
    } out_t;

    typedef struct packed {
        in_t         in;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rd;
        logic        chk_rd;
        logic [31:0] alu;
        logic [4:0]  wn;
        logic [31:0] pc;
        logic        err;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    in_t  ia, ib;

    logic        a_stall, b_stall, a_err, b_err;
    logic [2:0]  a_ctl, b_ctl;
    logic [31:0] a_rd, b_rd, a_alu, b_alu, a_pc, b_pc;
    logic [4:0]  a_wn, b_wn;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic [4:0] last_wn [2];
    bit         hold_known [2];

    vec_t vecs_a [12];
    vec_t vecs_b [5];

    always #5 clk = ~clk;

    mem_stage #(.LAT(2), .DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .mem_read(ia.rd), .mem_write(ia.wr), .in_ctl(ia.ctl),
        .in_alu_out(ia.alu), .in_rd2(ia.rd2), .in_wn(ia.wn), .in_pc(ia.pc),
        .stall(a_stall), .out_ctl(a_ctl), .out_rd(a_rd), .out_alu_out(a_alu),
        .out_wn(a_wn), .out_pc(a_pc), .out_err(a_err)
    );

    mem_stage #(.LAT(1), .DEPTH(256)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .mem_read(ib.rd), .mem_write(ib.wr), .in_ctl(ib.ctl),
        .in_alu_out(ib.alu), .in_rd2(ib.rd2), .in_wn(ib.wn), .in_pc(ib.pc),
        .stall(b_stall), .out_ctl(b_ctl), .out_rd(b_rd), .out_alu_out(b_alu),
        .out_wn(b_wn), .out_pc(b_pc), .out_err(b_err)
    );

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] ctl,
                                input logic [31:0] alu, input logic [31:0] rd2,
                                input logic [4:0] wn, input logic [31:0] pc,
                                input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.in.rd  = rd;
        v.in.wr  = wr;
        v.in.ctl = ctl;
        v.in.alu = alu;
        v.in.rd2 = rd2;
        v.in.wn  = wn;
        v.in.pc  = pc;
        v.exp_rd  = exp_rd;
        v.exp_err = exp_err;
        return v;
    endfunction

    function automatic out_t getOut(input int inst);
        out_t o;
        if (inst == 0) begin
            o.stall = a_stall; o.ctl = a_ctl; o.rd = a_rd; o.alu = a_alu;
            o.wn = a_wn; o.pc = a_pc; o.err = a_err;
        end else begin
            o.stall = b_stall; o.ctl = b_ctl; o.rd = b_rd; o.alu = b_alu;
            o.wn = b_wn; o.pc = b_pc; o.err = b_err;
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setIn(input int inst, input in_t v);
        if (inst == 0) ia = v;
        else           ib = v;
    endtask

    // Drive one instruction and queue what the MEM/WB bundle must hold when it completes
    task automatic applyStimulus(input int inst, input vec_t v);
        exp_t e;
        int   lat;
        logic valid;
        lat   = (inst == 0) ? 2 : 1;
        valid = (v.in.rd ^ v.in.wr) && (v.in.alu[1:0] == 2'b00);
        setIn(inst, v.in);
        e.err    = v.exp_err;
        e.ctl    = v.exp_err ? 3'b000 : v.in.ctl;
        e.rd     = v.exp_rd;
        e.chk_rd = !v.exp_err && !v.in.wr;
        e.alu    = v.in.alu;
        e.wn     = v.in.wn;
        e.pc     = v.in.pc;
        e.stalls = valid ? lat : 0;
        exp_q.push_back(e);
    endtask

    // Compare the completed MEM/WB bundle against the oldest queued expectation
    task automatic checkOutput(input int inst);
        exp_t e;
        out_t o;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got output with empty queue, expected a queued entry");
            return;
        end
        e = exp_q.pop_front();
        o = getOut(inst);
        check($sformatf("inst%0d out_ctl", inst), 32'(o.ctl), 32'(e.ctl));
        check($sformatf("inst%0d out_err", inst), 32'(o.err), 32'(e.err));
        if (!e.err) begin
            check($sformatf("inst%0d out_alu_out", inst), o.alu, e.alu);
            check($sformatf("inst%0d out_wn", inst), 32'(o.wn), 32'(e.wn));
            check($sformatf("inst%0d out_pc", inst), o.pc, e.pc);
        end
        if (e.chk_rd) check($sformatf("inst%0d out_rd", inst), o.rd, e.rd);
        hold_known[inst] = !e.err;
        last_wn[inst]    = e.wn;
    endtask

    // Run one instruction to completion, checking stall and bubbles every cycle;
    // flip swaps the request lines after the first edge to show they are ignored
    task automatic runOp(input int inst, input vec_t v, input bit flip);
        int   cyc;
        int   stalls;
        bit   done;
        logic s;
        out_t o;
        in_t  cur;
        applyStimulus(inst, v);
        stalls = exp_q[$].stalls;
        cyc    = 0;
        done   = 0;
        while (!done) begin
            #1;
            o = getOut(inst);
            s = o.stall;
            check($sformatf("inst%0d stall cycle %0d", inst, cyc), 32'(s), 32'(cyc < stalls));
            @(posedge clk);
            #1;
            if (s) begin
                o = getOut(inst);
                check($sformatf("inst%0d bubble ctl", inst), 32'(o.ctl), 32'd0);
                check($sformatf("inst%0d bubble err", inst), 32'(o.err), 32'd0);
                if (hold_known[inst])
                    check($sformatf("inst%0d bubble wn hold", inst), 32'(o.wn), 32'(last_wn[inst]));
                if (flip && cyc == 0) begin
                    cur    = (inst == 0) ? ia : ib;
                    cur.rd = ~cur.rd;
                    cur.wr = ~cur.wr;
                    setIn(inst, cur);
                end
            end else begin
                checkOutput(inst);
                done = 1;
            end
            cyc++;
            if (!done && cyc > 12) begin
                total++;
                bad++;
                $display("[TB] FAIL inst%0d timeout: got stall still high after %0d cycles, expected completion", inst, cyc);
                exp_q.delete();
                done = 1;
            end
        end
    endtask

    initial begin
        out_t o;

        vecs_a[0]  = mk(0, 1, 3'b101, 32'h10,  32'hDEADBEEF, 5'd3,  32'h100, 32'h0,        1'b0);
        vecs_a[1]  = mk(1, 0, 3'b011, 32'h10,  32'h0,        5'd9,  32'h104, 32'hDEADBEEF, 1'b0);
        vecs_a[2]  = mk(0, 0, 3'b001, 32'h1234, 32'hFFFF,    5'd7,  32'h108, 32'h0,        1'b0);
        vecs_a[3]  = mk(1, 0, 3'b011, 32'h13,  32'h0,        5'd4,  32'h10C, 32'h0,        1'b1);
        vecs_a[4]  = mk(1, 0, 3'b111, 32'h10,  32'h0,        5'd5,  32'h110, 32'hDEADBEEF, 1'b0);
        vecs_a[5]  = mk(1, 1, 3'b011, 32'h20,  32'h99,       5'd6,  32'h114, 32'h0,        1'b1);
        vecs_a[6]  = mk(0, 1, 3'b100, 32'h20,  32'h11112222, 5'd0,  32'h118, 32'h0,        1'b0);
        vecs_a[7]  = mk(1, 0, 3'b011, 32'h20,  32'h0,        5'd10, 32'h11C, 32'h11112222, 1'b0);
        vecs_a[8]  = mk(0, 1, 3'b100, 32'h410, 32'hCAFEF00D, 5'd0,  32'h120, 32'h0,        1'b0);
        vecs_a[9]  = mk(1, 0, 3'b011, 32'h10,  32'h0,        5'd11, 32'h124, 32'hCAFEF00D, 1'b0);
        vecs_a[10] = mk(0, 1, 3'b100, 32'h22,  32'h77777777, 5'd0,  32'h128, 32'h0,        1'b1);
        vecs_a[11] = mk(1, 0, 3'b011, 32'h20,  32'h0,        5'd12, 32'h12C, 32'h11112222, 1'b0);

        vecs_b[0] = mk(0, 1, 3'b100, 32'h40, 32'h01020304, 5'd0,  32'h200, 32'h0,        1'b0);
        vecs_b[1] = mk(0, 1, 3'b100, 32'h44, 32'h05060708, 5'd0,  32'h204, 32'h0,        1'b0);
        vecs_b[2] = mk(1, 0, 3'b011, 32'h40, 32'h0,        5'd13, 32'h208, 32'h01020304, 1'b0);
        vecs_b[3] = mk(1, 0, 3'b110, 32'h44, 32'h0,        5'd14, 32'h20C, 32'h05060708, 1'b0);
        vecs_b[4] = mk(1, 0, 3'b011, 32'h40, 32'h0,        5'd15, 32'h210, 32'h01020304, 1'b0);

        // Reset with a pending load on the inputs: stall and outputs stay at zero
        rst_n = 1'b0;
        ia    = mk(1, 0, 3'b111, 32'h10, 32'h0, 5'd1, 32'h4, 32'h0, 1'b0).in;
        ib    = '0;
        #1;
        o = getOut(0);
        check("reset stall", 32'(o.stall), 32'd0);
        check("reset out_ctl", 32'(o.ctl), 32'd0);
        check("reset out_rd", o.rd, 32'd0);
        check("reset out_pc", o.pc, 32'd0);
        check("reset out_err", 32'(o.err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        o = getOut(0);
        check("reset held out_wn", 32'(o.wn), 32'd0);
        check("reset held stall", 32'(o.stall), 32'd0);
        ia = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_wn[0] = 5'd0; last_wn[1] = 5'd0;
        hold_known[0] = 1; hold_known[1] = 1;

        $display("[TB] LAT=2 vector table");
        for (int i = 0; i < 12; i++) runOp(0, vecs_a[i], 1'b0);

        $display("[TB] request lines toggled while busy");
        runOp(0, mk(0, 1, 3'b101, 32'h30, 32'h55AA55AA, 5'd2, 32'h300, 32'h0, 1'b0), 1'b1);
        runOp(0, mk(1, 0, 3'b011, 32'h30, 32'h0, 5'd16, 32'h304, 32'h55AA55AA, 1'b0), 1'b0);

        $display("[TB] reset during a store");
        applyStimulus(0, mk(0, 1, 3'b101, 32'h20, 32'hA5A5A5A5, 5'd0, 32'h400, 32'h0, 1'b0));
        #1;
        check("abort stall before edge", 32'(a_stall), 32'd1);
        @(posedge clk);
        #1;
        check("abort bubble ctl", 32'(a_ctl), 32'd0);
        check("abort stall in busy", 32'(a_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        o = getOut(0);
        check("abort stall", 32'(o.stall), 32'd0);
        check("abort out_alu_out", o.alu, 32'd0);
        check("abort out_pc", o.pc, 32'd0);
        check("abort out_wn", 32'(o.wn), 32'd0);
        exp_q.delete();
        ia = '0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_wn[0] = 5'd0;
        hold_known[0] = 1;
        runOp(0, mk(0, 0, 3'b010, 32'h5678, 32'h0, 5'd8, 32'h404, 32'h0, 1'b0), 1'b0);
        runOp(0, mk(1, 0, 3'b011, 32'h20, 32'h0, 5'd17, 32'h408, 32'h11112222, 1'b0), 1'b0);

        $display("[TB] LAT=1 back-to-back");
        ia = '0;
        for (int i = 0; i < 5; i++) runOp(1, vecs_b[i], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
